reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//  Circular in-order retirement queue of the Tomasulo core. Dispatch allocates one entry per cycle
//  (launch -> RegisterFile rename); execution units write results over the CDB; head retires in order
//  (commit -> RegisterFile, store release -> LSB). Mispredicted branch at head flushes the machine.
// PARAMETERS
//  ROB_ID_W  5   entry-id width; DEPTH = 1<<ROB_ID_W (32)
//  XLEN      32  data/pc width
// PORTS
//  clk_in                  in  1     clock, single domain
//  rst_in                  in  1     asynchronous, active-high reset
//  rdy_in                  in  1     low = freeze all state, no pulses
//  _issue_valid            in  1     dispatch offers instruction
//  _issue_type             in  2     0 REG, 1 STORE, 2 BRANCH
//  _issue_rd               in  5     destination (REG only)
//  _rob_full               out 1     issue not accepted this cycle
//  _rob_free_id            out 5     id given to an accepted issue (=tail)
//  _rob_launch_ready       out 1     accepted REG issue with rd!=0 (combinational)
//  _rob_launch_rob_id      out 5     = tail
//  _rob_launch_register_id out 5     = _issue_rd
//  _cdb_valid              in  1     result broadcast
//  _cdb_rob_id             in  5     target entry
//  _cdb_value              in  XLEN  result (REG) / unused (STORE)
//  _cdb_mispredict         in  1     BRANCH only: prediction wrong
//  _cdb_target_pc          in  XLEN  BRANCH only: correct next pc
//  _query_rob_id_1/_2      in  5     dispatch operand lookup
//  _query_ready_1/_2       out 1     entry has value (includes same-cycle CDB hit)
//  _query_value_1/_2       out XLEN  entry value or bypassed _cdb_value
//  _rob_commit_ready       out 1     registered 1-cycle pulse: REG entry retired
//  _rob_commit_rob_id      out 5     retired id
//  _rob_commit_register_id out 5     retired rd
//  _rob_commit_value       out XLEN  retired value
//  _rob_store_commit       out 1     registered pulse: STORE at head may write memory
//  _rob_store_rob_id       out 5     that store's id
//  _rob_flush              out 1     registered 1-cycle flush pulse
//  _rob_flush_pc           out XLEN  refetch pc
// BEHAVIOUR
//  - Reset: head=tail=0, count=0, all entry valid/ready=0; every registered output 0.
//  - Accept = _issue_valid & !_rob_full & rdy_in. _rob_full = (count==DEPTH) | _rob_flush | !rdy_in.
//    Entry written {valid=1,ready=0,type,rd}; tail++ mod DEPTH (5-bit natural wrap). rd=0 -> no launch.
//  - CDB: sets ready, value, mispredict, target of entry _cdb_rob_id if valid; invalid id ignored.
//  - Retire (at most 1/cycle): head valid & ready -> pulse matching output next cycle, clear entry, head++.
//    Entry made ready by CDB in cycle N retires no earlier than edge N+1 (ready bit registered).
//  - BRANCH retire with mispredict: same edge clears all entries, head=tail=count=0; _rob_flush=1,
//    _rob_flush_pc=target for one cycle. During flush cycle issue and CDB are ignored.
//  - Simultaneous issue+retire: count unchanged; full is evaluated on pre-edge count (no issue into
//    a slot freed the same edge).
//  - count is ROB_ID_W+1 bits; count==DEPTH only when head==tail & valid[head].
//  - rdy_in low: no state change, pulses deassert; resumes unchanged.
// CONFIGURATION
//  ROB_PERF_CNT_EN defined: adds out port _rob_retired_cnt [31:0], +1 per retire (any type, incl.
//  flushing branch), wraps at 2^32, reset 0, not cleared by flush. Undefined: port and counter absent.
// STRUCTURE
//  rob_pkg: ROB_ID_W, XLEN, type encodings ROB_T_REG/STORE/BRANCH, entry struct.
//  Sub-module rob_entry_array: DEPTH entries, one write port (issue), one CDB update port, head read,
//  two query read ports; pointer/count/flush control stays in reorder_buffer.
// TESTING
//  1 Reset, issue REG rd=3 -> launch_ready=1 id=0; CDB id0 val 0x55 -> commit id0 rd3 0x55 next cycle.
//  2 32 issues without CDB -> _rob_full=1 after 32nd; 33rd ignored; retire one -> next issue gets id0.
//  3 CDB id1 before id0 ready -> no commit; CDB id0 -> commits id0 then id1 on consecutive cycles.
//  4 BRANCH id2 mispredict target 0x100 at head -> flush pulse pc 0x100, full=1 that cycle, ROB empty.
//  5 Query id5 while CDB writes id5 val 0xAB -> query_ready=1 value 0xAB same cycle.
//  6 STORE id0 ready + rdy_in low 3 cycles -> no pulse; rdy_in high -> _rob_store_commit id0 once.

Source files
------------

// File: rtl/rob_pkg.sv
// rob_pkg: shared widths, entry type encodings and entry layout for the reorder buffer
package rob_pkg;
  localparam int ROB_ID_W = 5;
  localparam int XLEN = 32;
  localparam int DEPTH = 1 << ROB_ID_W;
  typedef logic [ROB_ID_W-1:0] rob_id_t;
  typedef enum logic [1:0] {
    ROB_T_REG    = 2'd0,
    ROB_T_STORE  = 2'd1,
    ROB_T_BRANCH = 2'd2
  } rob_type_e;
  typedef struct packed {
    logic            valid;
    logic            ready;
    rob_type_e       typ;
    logic [4:0]      rd;
    logic [XLEN-1:0] value;
    logic            mispredict;
    logic [XLEN-1:0] target;
  } rob_entry_t;
endpackage

// File: rtl/reorder_buffer_if.sv
// reorder_buffer_if: dispatch, CDB, operand query, commit, store release and flush signals
interface reorder_buffer_if;
  import rob_pkg::*;
  logic            _issue_valid;
  logic [1:0]      _issue_type;
  logic [4:0]      _issue_rd;
  logic            _rob_full;
  rob_id_t         _rob_free_id;
  logic            _rob_launch_ready;
  rob_id_t         _rob_launch_rob_id;
  logic [4:0]      _rob_launch_register_id;
  logic            _cdb_valid;
  rob_id_t         _cdb_rob_id;
  logic [XLEN-1:0] _cdb_value;
  logic            _cdb_mispredict;
  logic [XLEN-1:0] _cdb_target_pc;
  rob_id_t         _query_rob_id_1;
  rob_id_t         _query_rob_id_2;
  logic            _query_ready_1;
  logic            _query_ready_2;
  logic [XLEN-1:0] _query_value_1;
  logic [XLEN-1:0] _query_value_2;
  logic            _rob_commit_ready;
  rob_id_t         _rob_commit_rob_id;
  logic [4:0]      _rob_commit_register_id;
  logic [XLEN-1:0] _rob_commit_value;
  logic            _rob_store_commit;
  rob_id_t         _rob_store_rob_id;
  logic            _rob_flush;
  logic [XLEN-1:0] _rob_flush_pc;
  modport master (
    output _issue_valid, _issue_type, _issue_rd, _cdb_valid, _cdb_rob_id, _cdb_value,
           _cdb_mispredict, _cdb_target_pc, _query_rob_id_1, _query_rob_id_2,
    input  _rob_full, _rob_free_id, _rob_launch_ready, _rob_launch_rob_id, _rob_launch_register_id,
           _query_ready_1, _query_ready_2, _query_value_1, _query_value_2, _rob_commit_ready,
           _rob_commit_rob_id, _rob_commit_register_id, _rob_commit_value, _rob_store_commit,
           _rob_store_rob_id, _rob_flush, _rob_flush_pc
  );
  modport slave (
    input  _issue_valid, _issue_type, _issue_rd, _cdb_valid, _cdb_rob_id, _cdb_value,
           _cdb_mispredict, _cdb_target_pc, _query_rob_id_1, _query_rob_id_2,
    output _rob_full, _rob_free_id, _rob_launch_ready, _rob_launch_rob_id, _rob_launch_register_id,
           _query_ready_1, _query_ready_2, _query_value_1, _query_value_2, _rob_commit_ready,
           _rob_commit_rob_id, _rob_commit_register_id, _rob_commit_value, _rob_store_commit,
           _rob_store_rob_id, _rob_flush, _rob_flush_pc
  );
endinterface

// File: rtl/rob_entry_array.sv
// rob_entry_array: entry storage with issue write, CDB update, head read and two bypassing query ports
module rob_entry_array
  import rob_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            en_i,
  input  logic            wr_en_i,
  input  rob_id_t         wr_id_i,
  input  rob_type_e       wr_type_i,
  input  logic [4:0]      wr_rd_i,
  input  logic            cdb_en_i,
  input  rob_id_t         cdb_id_i,
  input  logic [XLEN-1:0] cdb_value_i,
  input  logic            cdb_mispredict_i,
  input  logic [XLEN-1:0] cdb_target_i,
  input  logic            clr_one_i,
  input  logic            clr_all_i,
  input  rob_id_t         head_id_i,
  output rob_entry_t      head_o,
  input  rob_id_t         q1_id_i,
  input  rob_id_t         q2_id_i,
  output logic            q1_ready_o,
  output logic            q2_ready_o,
  output logic [XLEN-1:0] q1_value_o,
  output logic [XLEN-1:0] q2_value_o
);
  rob_entry_t ent_q [DEPTH];
  logic cdb_hit, q1_hit, q2_hit;
  // results for ids that are not allocated are dropped
  assign cdb_hit = cdb_en_i & ent_q[cdb_id_i].valid;
  assign q1_hit = cdb_hit & (cdb_id_i == q1_id_i);
  assign q2_hit = cdb_hit & (cdb_id_i == q2_id_i);
  assign head_o = ent_q[head_id_i];
  assign q1_ready_o = ent_q[q1_id_i].ready | q1_hit;
  assign q2_ready_o = ent_q[q2_id_i].ready | q2_hit;
  assign q1_value_o = q1_hit ? cdb_value_i : ent_q[q1_id_i].value;
  assign q2_value_o = q2_hit ? cdb_value_i : ent_q[q2_id_i].value;
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
    else if (en_i) begin
      if (clr_all_i) for (int i = 0; i < DEPTH; i++) ent_q[i] <= '0;
      else begin
        if (wr_en_i) ent_q[wr_id_i] <= '{valid: 1'b1, ready: 1'b0, typ: wr_type_i, rd: wr_rd_i,
                                         value: '0, mispredict: 1'b0, target: '0};
        if (cdb_hit) begin
          ent_q[cdb_id_i].ready <= 1'b1;
          ent_q[cdb_id_i].value <= cdb_value_i;
          ent_q[cdb_id_i].mispredict <= cdb_mispredict_i;
          ent_q[cdb_id_i].target <= cdb_target_i;
        end
        if (clr_one_i) ent_q[head_id_i] <= '0;
      end
    end
endmodule

// File: rtl/reorder_buffer.sv
// reorder_buffer: in-order retirement queue with CDB capture, operand query and mispredict flush
// Defining ROB_PERF_CNT_EN adds the _rob_retired_cnt retire counter port.
module reorder_buffer
  import rob_pkg::*;
(
  input logic clk_in,
  input logic rst_in,
  input logic rdy_in,
  reorder_buffer_if.slave bus
`ifdef ROB_PERF_CNT_EN
  ,
  output logic [31:0] _rob_retired_cnt
`endif
);
  localparam logic [ROB_ID_W:0] FULL_CNT = (ROB_ID_W+1)'(DEPTH);
  rob_id_t head_q, head_d, tail_q, tail_d, commit_id_q;
  logic [ROB_ID_W:0] count_q, count_d;
  logic flush_q, commit_q, store_q;
  logic [4:0] commit_rd_q;
  logic [XLEN-1:0] commit_value_q, flush_pc_q;
  rob_entry_t head_e;
  logic accept, retire, mispredict, cdb_en;
  assign bus._rob_full = (count_q == FULL_CNT) | flush_q | !rdy_in;
  assign accept = bus._issue_valid & !bus._rob_full;
  assign retire = rdy_in & head_e.valid & head_e.ready;
  assign mispredict = retire & (head_e.typ == ROB_T_BRANCH) & head_e.mispredict;
  assign cdb_en = bus._cdb_valid & rdy_in & !flush_q;
  assign bus._rob_free_id = tail_q;
  assign bus._rob_launch_ready = accept & (bus._issue_type == ROB_T_REG) & (bus._issue_rd != '0);
  assign bus._rob_launch_rob_id = tail_q;
  assign bus._rob_launch_register_id = bus._issue_rd;
  assign bus._rob_commit_ready = commit_q;
  assign bus._rob_commit_rob_id = commit_id_q;
  assign bus._rob_commit_register_id = commit_rd_q;
  assign bus._rob_commit_value = commit_value_q;
  assign bus._rob_store_commit = store_q;
  assign bus._rob_store_rob_id = commit_id_q;
  assign bus._rob_flush = flush_q;
  assign bus._rob_flush_pc = flush_pc_q;
  // full uses the pre-edge count, so a slot freed this edge is never reissued in the same cycle
  always_comb begin
    head_d = mispredict ? '0 : head_q + rob_id_t'(retire);
    tail_d = mispredict ? '0 : tail_q + rob_id_t'(accept);
    count_d = mispredict ? '0 : count_q + (ROB_ID_W+1)'(accept) - (ROB_ID_W+1)'(retire);
  end
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
      flush_q <= 1'b0;
      commit_q <= 1'b0;
      store_q <= 1'b0;
      commit_id_q <= '0;
      commit_rd_q <= '0;
      commit_value_q <= '0;
      flush_pc_q <= '0;
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
      flush_q <= mispredict;
      commit_q <= retire & (head_e.typ == ROB_T_REG);
      store_q <= retire & (head_e.typ == ROB_T_STORE);
      if (retire) begin
        commit_id_q <= head_q;
        commit_rd_q <= head_e.rd;
        commit_value_q <= head_e.value;
      end
      if (mispredict) flush_pc_q <= head_e.target;
    end
`ifdef ROB_PERF_CNT_EN
  logic [31:0] retired_cnt_q;
  always_ff @(posedge clk_in or posedge rst_in)
    if (rst_in) retired_cnt_q <= '0;
    else if (retire) retired_cnt_q <= retired_cnt_q + 32'd1;
  assign _rob_retired_cnt = retired_cnt_q;
`endif
  rob_entry_array u_entries (
    .clk              (clk_in),
    .rst              (rst_in),
    .en_i             (rdy_in),
    .wr_en_i          (accept),
    .wr_id_i          (tail_q),
    .wr_type_i        (rob_type_e'(bus._issue_type)),
    .wr_rd_i          (bus._issue_rd),
    .cdb_en_i         (cdb_en),
    .cdb_id_i         (bus._cdb_rob_id),
    .cdb_value_i      (bus._cdb_value),
    .cdb_mispredict_i (bus._cdb_mispredict),
    .cdb_target_i     (bus._cdb_target_pc),
    .clr_one_i        (retire),
    .clr_all_i        (mispredict),
    .head_id_i        (head_q),
    .head_o           (head_e),
    .q1_id_i          (bus._query_rob_id_1),
    .q2_id_i          (bus._query_rob_id_2),
    .q1_ready_o       (bus._query_ready_1),
    .q2_ready_o       (bus._query_ready_2),
    .q1_value_o       (bus._query_value_1),
    .q2_value_o       (bus._query_value_2)
  );
endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer: directed scenarios plus random traffic checked against a queue-based ROB model
module tb_reorder_buffer;
  import rob_pkg::*;
  logic clk_in = 1'b0;
  logic rst_in = 1'b1;
  logic rdy_in = 1'b0;
  reorder_buffer_if bus ();
  always #5 clk_in = ~clk_in;
`ifdef ROB_PERF_CNT_EN
  logic [31:0] retired_cnt;
  reorder_buffer dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus), ._rob_retired_cnt(retired_cnt));
`else
  reorder_buffer dut (.clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .bus(bus));
`endif

  typedef struct {int typ; int rd; bit rdy; logic [31:0] val; bit mis; logic [31:0] tgt;} ment_t;
  ment_t mq[$];
  int mhead;
  bit m_cr, m_sc, m_fl;
  int m_cid, m_crd;
  logic [31:0] m_cval, m_fpc, m_cnt;
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic int slot(input int id);
    return (id - mhead) & 31;
  endfunction

  function automatic void qexp(input int qid, input bit cok, output bit r, output logic [31:0] v);
    int k = slot(qid);
    bit hit = cok && (int'(bus._cdb_rob_id) == qid);
    r = 1'b0;
    v = 32'h0;
    if (k < mq.size()) begin
      r = mq[k].rdy || hit;
      v = hit ? bus._cdb_value : mq[k].val;
    end
  endfunction

  // model: ROB as a queue of in-flight instructions, oldest first
  always @(negedge clk_in) begin
    int n, tail, ck;
    bit full, acc, cok, ret, mis, r;
    logic [31:0] v;
    if (rst_in) begin
      mq.delete();
      mhead = 0;
      m_cr = 0; m_sc = 0; m_fl = 0;
      m_cnt = 0;
    end else begin
      n = mq.size();
      tail = (mhead + n) & 31;
      full = (n == 32) || m_fl || !rdy_in;
      acc = bus._issue_valid && !full;
      ck = slot(int'(bus._cdb_rob_id));
      cok = bus._cdb_valid && rdy_in && !m_fl && (ck < n);
      ret = 0;
      if (rdy_in && n > 0) ret = mq[0].rdy;
      mis = 0;
      if (ret) mis = (mq[0].typ == 2) && mq[0].mis;
      chk("full", 32'(bus._rob_full), 32'(full));
      chk("free_id", 32'(bus._rob_free_id), 32'(tail));
      chk("launch", 32'(bus._rob_launch_ready), 32'(acc && bus._issue_type == 2'd0 && bus._issue_rd != 5'd0));
      if (acc) begin
        chk("launch_id", 32'(bus._rob_launch_rob_id), 32'(tail));
        chk("launch_rd", 32'(bus._rob_launch_register_id), 32'(bus._issue_rd));
      end
      qexp(int'(bus._query_rob_id_1), cok, r, v);
      chk("q1_ready", 32'(bus._query_ready_1), 32'(r));
      if (r) chk("q1_value", bus._query_value_1, v);
      qexp(int'(bus._query_rob_id_2), cok, r, v);
      chk("q2_ready", 32'(bus._query_ready_2), 32'(r));
      if (r) chk("q2_value", bus._query_value_2, v);
      chk("commit", 32'(bus._rob_commit_ready), 32'(m_cr));
      if (m_cr) begin
        chk("commit_id", 32'(bus._rob_commit_rob_id), 32'(m_cid));
        chk("commit_rd", 32'(bus._rob_commit_register_id), 32'(m_crd));
        chk("commit_val", bus._rob_commit_value, m_cval);
      end
      chk("store", 32'(bus._rob_store_commit), 32'(m_sc));
      if (m_sc) chk("store_id", 32'(bus._rob_store_rob_id), 32'(m_cid));
      chk("flush", 32'(bus._rob_flush), 32'(m_fl));
      if (m_fl) chk("flush_pc", bus._rob_flush_pc, m_fpc);
`ifdef ROB_PERF_CNT_EN
      chk("retired_cnt", retired_cnt, m_cnt);
`endif
      m_cr = ret && mq[0].typ == 0;
      m_sc = ret && mq[0].typ == 1;
      m_fl = mis;
      if (ret) begin
        m_cid = mhead;
        m_crd = mq[0].rd;
        m_cval = mq[0].val;
        m_cnt++;
      end
      if (mis) m_fpc = mq[0].tgt;
      if (cok) begin
        mq[ck].rdy = 1'b1;
        mq[ck].val = bus._cdb_value;
        mq[ck].mis = bus._cdb_mispredict;
        mq[ck].tgt = bus._cdb_target_pc;
      end
      if (mis) begin
        mq.delete();
        mhead = 0;
      end else begin
        if (ret) begin
          void'(mq.pop_front());
          mhead = (mhead + 1) & 31;
        end
        if (acc) mq.push_back('{typ: int'(bus._issue_type), rd: int'(bus._issue_rd), rdy: 1'b0,
                                 val: 32'h0, mis: 1'b0, tgt: 32'h0});
      end
    end
  end

  task automatic cyc();
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle();
    bus._issue_valid = 1'b0;
    bus._cdb_valid = 1'b0;
    bus._cdb_mispredict = 1'b0;
    rdy_in = 1'b1;
  endtask

  task automatic issue(input int t, input int rd);
    bus._issue_valid = 1'b1;
    bus._issue_type = 2'(t);
    bus._issue_rd = 5'(rd);
  endtask

  task automatic cdb(input int id, input logic [31:0] v, input bit m, input logic [31:0] tg);
    bus._cdb_valid = 1'b1;
    bus._cdb_rob_id = 5'(id);
    bus._cdb_value = v;
    bus._cdb_mispredict = m;
    bus._cdb_target_pc = tg;
  endtask

  initial begin
    int w;
    int id;
    idle();
    bus._issue_type = 2'd0;
    bus._issue_rd = 5'd0;
    bus._cdb_rob_id = 5'd0;
    bus._cdb_value = 32'h0;
    bus._cdb_target_pc = 32'h0;
    bus._query_rob_id_1 = 5'd0;
    bus._query_rob_id_2 = 5'd0;
    repeat (3) cyc();
    rst_in = 1'b0;
    #1;
    chk("rst_full", 32'(bus._rob_full), 0);
    chk("rst_free_id", 32'(bus._rob_free_id), 0);
    chk("rst_commit", 32'(bus._rob_commit_ready), 0);
    chk("rst_flush", 32'(bus._rob_flush), 0);
    chk("rst_flush_pc", bus._rob_flush_pc, 0);
    // scenario 1: single REG instruction end to end
    cyc(); issue(0, 3); #1;
    chk("t1_launch", 32'(bus._rob_launch_ready), 1);
    chk("t1_launch_id", 32'(bus._rob_launch_rob_id), 0);
    chk("t1_launch_rd", 32'(bus._rob_launch_register_id), 3);
    cyc(); idle(); cdb(0, 32'h55, 0, 0);
    cyc(); idle(); #1;
    chk("t1_no_commit_yet", 32'(bus._rob_commit_ready), 0);
    cyc(); #1;
    chk("t1_commit", 32'(bus._rob_commit_ready), 1);
    chk("t1_commit_id", 32'(bus._rob_commit_rob_id), 0);
    chk("t1_commit_rd", 32'(bus._rob_commit_register_id), 3);
    chk("t1_commit_val", bus._rob_commit_value, 32'h55);
    // scenario 2: fill all 32 slots starting from id 1
    for (int i = 0; i < 32; i++) begin
      cyc(); idle(); issue(0, (i % 31) + 1);
    end
    cyc(); idle(); issue(0, 7); #1;
    chk("t2_full", 32'(bus._rob_full), 1);
    chk("t2_33rd_ignored", 32'(bus._rob_launch_ready), 0);
    chk("t2_free_id", 32'(bus._rob_free_id), 1);
    // scenario 5: query bypass of a same-cycle CDB write
    cyc(); idle(); cdb(5, 32'hAB, 0, 0); bus._query_rob_id_1 = 5'd5; bus._query_rob_id_2 = 5'd6; #1;
    chk("t5_q_ready", 32'(bus._query_ready_1), 1);
    chk("t5_q_value", bus._query_value_1, 32'hAB);
    chk("t5_q2_not_ready", 32'(bus._query_ready_2), 0);
    cyc(); idle(); cdb(1, 32'h11, 0, 0);
    cyc(); idle(); issue(0, 9); #1;
    chk("t2_full_at_retire", 32'(bus._rob_full), 1);
    chk("t2_no_launch_at_retire", 32'(bus._rob_launch_ready), 0);
    cyc(); idle(); issue(0, 9); #1;
    chk("t2_commit_id1", 32'(bus._rob_commit_rob_id), 1);
    chk("t2_not_full", 32'(bus._rob_full), 0);
    chk("t2_reuse_launch", 32'(bus._rob_launch_ready), 1);
    chk("t2_reuse_id", 32'(bus._rob_launch_rob_id), 1);
    // scenario 3: younger result waits for the head
    cyc(); idle(); cdb(3, 32'h33, 0, 0);
    cyc(); idle();
    cyc(); #1;
    chk("t3_no_commit", 32'(bus._rob_commit_ready), 0);
    idle(); cdb(2, 32'h22, 0, 0);
    cyc(); idle();
    cyc(); #1;
    chk("t3_commit_a", 32'(bus._rob_commit_ready), 1);
    chk("t3_commit_a_id", 32'(bus._rob_commit_rob_id), 2);
    chk("t3_commit_a_val", bus._rob_commit_value, 32'h22);
    cyc(); #1;
    chk("t3_commit_b", 32'(bus._rob_commit_ready), 1);
    chk("t3_commit_b_id", 32'(bus._rob_commit_rob_id), 3);
    chk("t3_commit_b_val", bus._rob_commit_value, 32'h33);
    cyc(); #1;
    chk("t3_blocked_head", 32'(bus._rob_commit_ready), 0);
    // scenario 4: mispredicted branch at id 2 flushes
    cyc(); rst_in = 1'b1; idle();
    cyc(); rst_in = 1'b0;
    issue(0, 1);
    cyc(); idle(); issue(0, 2);
    cyc(); idle(); issue(2, 0);
    cyc(); idle(); cdb(2, 32'h0, 1, 32'h100);
    cyc(); idle(); cdb(0, 32'h1, 0, 0);
    cyc(); idle(); cdb(1, 32'h2, 0, 0);
    cyc(); idle(); #1;
    w = 0;
    while (!bus._rob_flush && w < 12) begin
      cyc(); #1;
      w++;
    end
    issue(0, 4); #1;
    chk("t4_flush", 32'(bus._rob_flush), 1);
    chk("t4_flush_pc", bus._rob_flush_pc, 32'h100);
    chk("t4_full_in_flush", 32'(bus._rob_full), 1);
    chk("t4_no_launch_in_flush", 32'(bus._rob_launch_ready), 0);
    chk("t4_empty", 32'(bus._rob_free_id), 0);
    // scenario 6: store release frozen by rdy_in
    cyc(); idle(); issue(1, 0); #1;
    chk("t4_flush_once", 32'(bus._rob_flush), 0);
    chk("t4_accepts_after", 32'(bus._rob_full), 0);
    chk("t6_store_id", 32'(bus._rob_launch_rob_id), 0);
    cyc(); idle(); cdb(0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(); idle(); rdy_in = 1'b0; #1;
      chk("t6_frozen", 32'(bus._rob_store_commit), 0);
    end
    cyc(); idle(); #1;
    chk("t6_retire_cycle", 32'(bus._rob_store_commit), 0);
    cyc(); #1;
    chk("t6_store", 32'(bus._rob_store_commit), 1);
    chk("t6_store_rob_id", 32'(bus._rob_store_rob_id), 0);
    cyc(); #1;
    chk("t6_store_once", 32'(bus._rob_store_commit), 0);
    // random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      cyc(); idle();
      rdy_in = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 9) < 6) issue($urandom_range(0, 2), $urandom_range(0, 31));
      if ($urandom_range(0, 9) < 7) begin
        id = $urandom_range(0, 31);
        if (mq.size() > 0 && $urandom_range(0, 3) != 0) id = (mhead + $urandom_range(0, mq.size() - 1)) & 31;
        cdb(id, $urandom, $urandom_range(0, 7) == 0, $urandom);
      end
      bus._query_rob_id_1 = ($urandom_range(0, 1) != 0) ? bus._cdb_rob_id : 5'($urandom);
      bus._query_rob_id_2 = 5'($urandom);
    end
    cyc(); idle(); cyc();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
